scaled_window_timing: RTL and testbench

- Generalised timing and fetch sequencer for the upscaled GBA window inside the HDMI raster.
- Takes the HDMI core's cx/cy raster position and frame size. Produces window-draw, line-cache fetch and subpixel-phase signals, with independent integer X/Y scale factors and a configurable fetch lead.
- Adds a frame-lock state machine with miss tolerance and a watchdog. It gates the HDMI core enable and requests resync when the GBA frame strobe drifts.

---
 rtl/scaled_window_timing_if.sv | 37 +++
 rtl/scaled_window_timing.sv | 219 +++++++++++++++++++++
 tb/tb_scaled_window_timing.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scaled_window_timing_if.sv
// Raster bundle between the HDMI raster generator and the scaled window
// timing block: raster position and frame size in, window/fetch/lock status out.
interface scaled_window_timing_if;
    // There is no valid/ready handshake on this bundle. Every input is sampled
    // on every pxlClk edge. Every output is a registered level or a one-cycle
    // pulse that the consumer must take in the cycle it is asserted.
    logic [11:0] cx;
    logic [10:0] cy;
    logic [11:0] frameWidth;
    logic [10:0] frameHeight;
    logic        sameLine;
    logic        newFrameIn;

    logic        drawWin;
    logic        cacheUpdate;
    logic        nextLine;
    logic [7:0]  curPxl;
    logic [2:0]  gridXCnt;
    logic [2:0]  lineCnt;
    logic        hdmiEnable;
    logic        locked;
    logic        resyncPulse;

    // Raster side: drives position and frame size, consumes timing and lock status.
    modport master (
        output cx, cy, frameWidth, frameHeight, sameLine, newFrameIn,
        input  drawWin, cacheUpdate, nextLine, curPxl, gridXCnt, lineCnt,
        input  hdmiEnable, locked, resyncPulse
    );

    // Timing block side.
    modport slave (
        input  cx, cy, frameWidth, frameHeight, sameLine, newFrameIn,
        output drawWin, cacheUpdate, nextLine, curPxl, gridXCnt, lineCnt,
        output hdmiEnable, locked, resyncPulse
    );
endinterface

// File: rtl/scaled_window_timing.sv
// Timing and fetch sequencer for the integer-upscaled GBA window centred in
// the HDMI raster, plus a frame-lock FSM that gates the HDMI core and asks for
// a resync when the GBA frame strobe drifts or disappears.
module scaled_window_timing #(
    parameter int SRC_W          = 240,
    parameter int SRC_H          = 160,
    parameter int SCALE_X        = 4,
    parameter int SCALE_Y        = 4,
    parameter int FRAME_W        = 1280,
    parameter int FRAME_H        = 720,
    parameter int FETCH_LEAD     = 3,
    parameter int RESYNC_MISSES  = 2,
    parameter int TIMEOUT_FRAMES = 3
) (
    input  logic                   pxlClk,
    input  logic                   rst,
    scaled_window_timing_if.slave  bus
);
    // Window geometry, fixed at elaboration.
    localparam int X_START = (FRAME_W - SCALE_X * SRC_W) / 2;
    localparam int Y_START = (FRAME_H - SCALE_Y * SRC_H) / 2;
    localparam int X_STOP  = X_START + SCALE_X * SRC_W;
    localparam int Y_STOP  = Y_START + SCALE_Y * SRC_H;

    localparam logic [11:0] XSTART_C   = 12'(X_START);
    localparam logic [11:0] XSTOP_C    = 12'(X_STOP);
    localparam logic [11:0] FETCH_LO_C = 12'(X_START - FETCH_LEAD);
    localparam logic [11:0] FETCH_HI_C = 12'(X_STOP - FETCH_LEAD);
    localparam logic [10:0] YSTART_C   = 11'(Y_START);
    localparam logic [10:0] YSTOP_C    = 11'(Y_STOP);
    localparam logic [10:0] YSTART_M1  = 11'(Y_START - 1);
    localparam logic [2:0]  SX_MAX     = 3'(SCALE_X - 1);
    localparam logic [2:0]  SY_MAX     = 3'(SCALE_Y - 1);
    localparam logic [7:0]  PXL_MAX    = 8'(SRC_W - 1);
    localparam logic [3:0]  MISS_LIM   = 4'(RESYNC_MISSES);
    localparam logic [3:0]  TO_LIM     = 4'(TIMEOUT_FRAMES);

    // The window must fit in the frame with room for the fetch lead.
    if (X_START < 0 || Y_START < 0 || X_START < FETCH_LEAD) begin : g_bad_geometry
        $error("scaled_window_timing: window does not fit the frame with the fetch lead");
    end
    if (SCALE_X < 1 || SCALE_X > 8 || SCALE_Y < 1 || SCALE_Y > 8) begin : g_bad_scale
        $error("scaled_window_timing: scale factors must be 1..8");
    end
    if (RESYNC_MISSES < 1 || RESYNC_MISSES > 15 ||
        TIMEOUT_FRAMES < 1 || TIMEOUT_FRAMES > 15) begin : g_bad_lock
        $error("scaled_window_timing: lock limits must be 1..15");
    end

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // Raster decodes.
    logic in_x, in_y, at_xstop, line_end, frame_end, on_time, frame_edge;

    assign in_x       = (bus.cx >= XSTART_C) && (bus.cx < XSTOP_C);
    assign in_y       = (bus.cy >= YSTART_C) && (bus.cy < YSTOP_C);
    assign at_xstop   = (bus.cx == XSTOP_C);
    assign line_end   = (bus.cx == bus.frameWidth - 12'd1);
    assign frame_end  = line_end && (bus.cy == bus.frameHeight - 11'd1);
    assign on_time    = (bus.cy == YSTART_M1) || (bus.cy == YSTART_C);

    // Datapath registers.
    logic       draw_q, draw_d;
    logic       cache_q, cache_d;
    logic       next_line_q, next_line_d;
    logic [2:0] grid_q, grid_d;
    logic [2:0] phase_q, phase_d;
    logic [7:0] cur_q, cur_d;
    logic [2:0] line_cnt_q, line_cnt_d;

    // Lock FSM registers.
    state_t     state_q, state_d;
    logic [3:0] miss_q, miss_d;
    logic [3:0] frame_q, frame_d;
    logic       resync_q, resync_d;
    logic       nf_q;
    logic [3:0] miss_inc, frame_inc;

    assign frame_edge = bus.newFrameIn && !nf_q;
    assign miss_inc   = miss_q + 4'd1;
    assign frame_inc  = frame_q + 4'd1;

    // Next values of the window, subpixel-phase, fetch and line counters.
    always_comb begin
        draw_d      = in_x && in_y;
        cache_d     = at_xstop;
        next_line_d = at_xstop && !bus.sameLine && in_y && (line_cnt_q == SY_MAX);

        grid_d = grid_q + 3'd1;
        if (bus.cx == XSTART_C || grid_q == SX_MAX) begin
            grid_d = 3'd0;
        end

        // The fetch counter runs FETCH_LEAD cycles ahead of the window so the
        // line cache has the pixel ready when drawing reaches it.
        phase_d = phase_q;
        cur_d   = cur_q;
        if (bus.cx <= FETCH_LO_C || bus.cx > FETCH_HI_C) begin
            phase_d = 3'd0;
            cur_d   = 8'd0;
        end else if (phase_q == SX_MAX) begin
            phase_d = 3'd0;
            if (cur_q != PXL_MAX) begin
                cur_d = cur_q + 8'd1;
            end
        end else begin
            phase_d = phase_q + 3'd1;
        end

        line_cnt_d = line_cnt_q;
        if (line_end) begin
            if (bus.cy == bus.frameHeight - 11'd1) begin
                line_cnt_d = 3'd0;
            end else if (line_cnt_q == SY_MAX) begin
                line_cnt_d = 3'd0;
            end else if (bus.cy >= YSTART_C) begin
                line_cnt_d = line_cnt_q + 3'd1;
            end
        end
    end

    // Datapath register bank.
    always_ff @(posedge pxlClk or negedge rst) begin
        if (!rst) begin
            draw_q      <= 1'b0;
            cache_q     <= 1'b0;
            next_line_q <= 1'b0;
            grid_q      <= 3'd0;
            phase_q     <= 3'd0;
            cur_q       <= 8'd0;
            line_cnt_q  <= 3'd0;
        end else begin
            draw_q      <= draw_d;
            cache_q     <= cache_d;
            next_line_q <= next_line_d;
            grid_q      <= grid_d;
            phase_q     <= phase_d;
            cur_q       <= cur_d;
            line_cnt_q  <= line_cnt_d;
        end
    end

    // Lock FSM state register, its counters, strobe delay and resync pulse.
    always_ff @(posedge pxlClk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_UNLOCKED;
            miss_q   <= 4'd0;
            frame_q  <= 4'd0;
            resync_q <= 1'b0;
            nf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            miss_q   <= miss_d;
            frame_q  <= frame_d;
            resync_q <= resync_d;
            nf_q     <= bus.newFrameIn;
        end
    end

    // Lock FSM next state: a strobe edge beats a simultaneous frame wrap.
    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        frame_d = frame_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (frame_edge) begin
                    state_d = ST_LOCKED;
                    miss_d  = 4'd0;
                    frame_d = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (frame_edge) begin
                    frame_d = 4'd0;
                    if (on_time) begin
                        miss_d = 4'd0;
                    end else if (miss_inc >= MISS_LIM) begin
                        state_d = ST_UNLOCKED;
                        miss_d  = 4'd0;
                    end else begin
                        miss_d = miss_inc;
                    end
                end else if (frame_end) begin
                    if (frame_inc >= TO_LIM) begin
                        state_d = ST_UNLOCKED;
                        frame_d = 4'd0;
                    end else begin
                        frame_d = frame_inc;
                    end
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
        resync_d = (state_q == ST_LOCKED) && (state_d == ST_UNLOCKED);
    end

    // Lock FSM outputs; locked is the FSM state itself.
    always_comb begin
        bus.hdmiEnable = 1'b0;
        bus.locked     = 1'b0;
        if (state_q == ST_LOCKED) begin
            bus.hdmiEnable = 1'b1;
            bus.locked     = 1'b1;
        end
    end

    assign bus.drawWin     = draw_q;
    assign bus.cacheUpdate = cache_q;
    assign bus.nextLine    = next_line_q;
    assign bus.curPxl      = cur_q;
    assign bus.gridXCnt    = grid_q;
    assign bus.lineCnt     = line_cnt_q;
    assign bus.resyncPulse = resync_q;

endmodule

// File: tb/tb_scaled_window_timing.sv
// Directed bench for scaled_window_timing: default geometry on one instance,
// SCALE_X=3 / SCALE_Y=5 / FRAME_H=1080 on a second instance.
module tb_scaled_window_timing;
    logic pxlClk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    scaled_window_timing_if b1 ();
    scaled_window_timing_if b2 ();

    scaled_window_timing dut1 (
        .pxlClk (pxlClk),
        .rst    (rst),
        .bus    (b1)
    );

    scaled_window_timing #(
        .SCALE_X (3),
        .SCALE_Y (5),
        .FRAME_H (1080)
    ) dut2 (
        .pxlClk (pxlClk),
        .rst    (rst),
        .bus    (b2)
    );

    // Clock
    initial begin
        pxlClk = 1'b0;
        forever #5 pxlClk = ~pxlClk;
    end

    // Hard time limit
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a raster position to both instances and sample just after the edge.
    task automatic tick(input int x, input int y);
        b1.cx = 12'(x);
        b1.cy = 11'(y);
        b2.cx = 12'(x);
        b2.cy = 11'(y);
        @(posedge pxlClk);
        #1;
    endtask

    task automatic strobe(input int y);
        b1.newFrameIn = 1'b1;
        tick(0, y);
    endtask

    task automatic idle(input int y);
        b1.newFrameIn = 1'b0;
        tick(0, y);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".drawWin"},     b1.drawWin,     0);
        check({tag, ".cacheUpdate"}, b1.cacheUpdate, 0);
        check({tag, ".nextLine"},    b1.nextLine,    0);
        check({tag, ".curPxl"},      b1.curPxl,      0);
        check({tag, ".gridXCnt"},    b1.gridXCnt,    0);
        check({tag, ".lineCnt"},     b1.lineCnt,     0);
        check({tag, ".hdmiEnable"},  b1.hdmiEnable,  0);
        check({tag, ".locked"},      b1.locked,      0);
        check({tag, ".resyncPulse"}, b1.resyncPulse, 0);
    endtask

    initial begin
        int exp_cur;

        rst            = 1'b0;
        b1.cx          = '0;
        b1.cy          = '0;
        b1.frameWidth  = 12'd1650;
        b1.frameHeight = 11'd750;
        b1.sameLine    = 1'b0;
        b1.newFrameIn  = 1'b0;
        b2.cx          = '0;
        b2.cy          = '0;
        b2.frameWidth  = 12'd1650;
        b2.frameHeight = 11'd750;
        b2.sameLine    = 1'b0;
        b2.newFrameIn  = 1'b0;

        // Reset state
        tick(200, 100);
        tick(200, 100);
        check_all_zero("reset");
        rst = 1'b1;
        tick(0, 0);
        check("post_reset.locked", b1.locked, 0);
        check("post_reset.hdmiEnable", b1.hdmiEnable, 0);
        check("post_reset.resyncPulse", b1.resyncPulse, 0);

        // Lock on first strobe edge; holding the strobe high changes nothing
        strobe(0);
        check("lock.locked", b1.locked, 1);
        check("lock.hdmiEnable", b1.hdmiEnable, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0);
            check("lock_hold.locked", b1.locked, 1);
            check("lock_hold.resyncPulse", b1.resyncPulse, 0);
        end
        idle(0);

        // Default window along cy=40: xStart=160, xStop=1120
        for (int x = 150; x <= 1125; x++) begin
            tick(x, 40);
            check($sformatf("win1.drawWin@%0d", x), b1.drawWin, (x >= 160 && x < 1120) ? 1 : 0);
            if (x >= 160 && x < 1120) begin
                check($sformatf("win1.gridXCnt@%0d", x), b1.gridXCnt, (x - 160) % 4);
            end
            exp_cur = (x <= 157 || x > 1117) ? 0 : (x - 157) / 4;
            if (exp_cur > 239) exp_cur = 239;
            check($sformatf("win1.curPxl@%0d", x), b1.curPxl, exp_cur);
        end
        tick(500, 39);
        check("win1.drawWin_y39", b1.drawWin, 0);
        tick(500, 40);
        check("win1.drawWin_y40", b1.drawWin, 1);
        tick(500, 679);
        check("win1.drawWin_y679", b1.drawWin, 1);
        tick(500, 680);
        check("win1.drawWin_y680", b1.drawWin, 0);

        // SCALE_X=3 window along cy=140: xStart=280, xStop=1000, yStart=140
        for (int x = 270; x <= 1005; x++) begin
            tick(x, 140);
            check($sformatf("win2.drawWin@%0d", x), b2.drawWin, (x >= 280 && x < 1000) ? 1 : 0);
            if (x >= 280 && x < 1000) begin
                check($sformatf("win2.gridXCnt@%0d", x), b2.gridXCnt, (x - 280) % 3);
            end
            exp_cur = (x <= 277 || x > 997) ? 0 : (x - 277) / 3;
            if (exp_cur > 239) exp_cur = 239;
            check($sformatf("win2.curPxl@%0d", x), b2.curPxl, exp_cur);
        end
        tick(500, 139);
        check("win2.drawWin_y139", b2.drawWin, 0);
        tick(500, 939);
        check("win2.drawWin_y939", b2.drawWin, 1);
        tick(500, 940);
        check("win2.drawWin_y940", b2.drawWin, 0);

        // lineCnt wrap at SCALE_Y-1 on both instances, then frame-end clear
        for (int y = 140; y <= 144; y++) begin
            tick(1649, y);
            check($sformatf("line2.lineCnt@%0d", y), b2.lineCnt, (y - 139) % 5);
            check($sformatf("line1.lineCnt@%0d", y), b1.lineCnt, (y - 139) % 4);
        end
        tick(1649, 749);
        check("frame_end.lineCnt1", b1.lineCnt, 0);
        check("frame_end.lineCnt2", b2.lineCnt, 0);
        check("frame_end.locked", b1.locked, 1);

        // Line advance
        tick(1649, 40);
        tick(1649, 41);
        check("adv.lineCnt2", b1.lineCnt, 2);
        tick(1120, 43);
        check("adv_lc2.cacheUpdate", b1.cacheUpdate, 1);
        check("adv_lc2.nextLine", b1.nextLine, 0);
        tick(1121, 43);
        check("adv_lc2_after.cacheUpdate", b1.cacheUpdate, 0);
        tick(1649, 42);
        check("adv.lineCnt3", b1.lineCnt, 3);
        tick(1120, 43);
        check("adv_lc3.nextLine", b1.nextLine, 1);
        check("adv_lc3.cacheUpdate", b1.cacheUpdate, 1);
        tick(1121, 43);
        check("adv_lc3_after.nextLine", b1.nextLine, 0);
        check("adv_lc3_after.cacheUpdate", b1.cacheUpdate, 0);
        b1.sameLine = 1'b1;
        tick(1120, 43);
        check("adv_same.nextLine", b1.nextLine, 0);
        check("adv_same.cacheUpdate", b1.cacheUpdate, 1);
        b1.sameLine = 1'b0;
        tick(1120, 680);
        check("adv_outside_y.nextLine", b1.nextLine, 0);
        check("adv_outside_y.cacheUpdate", b1.cacheUpdate, 1);
        tick(1649, 43);
        check("adv.lineCnt_wrap", b1.lineCnt, 0);
        tick(1649, 39);
        check("adv.lineCnt_above_window", b1.lineCnt, 0);

        // Misaligned strobes with RESYNC_MISSES=2
        strobe(300);
        check("miss1.locked", b1.locked, 1);
        check("miss1.resyncPulse", b1.resyncPulse, 0);
        idle(300);
        strobe(40);
        check("ontime40.locked", b1.locked, 1);
        idle(40);
        strobe(300);
        check("miss_a.locked", b1.locked, 1);
        idle(300);
        tick(1649, 749);
        strobe(39);
        check("ontime39.locked", b1.locked, 1);
        idle(39);
        strobe(300);
        check("miss_b.locked", b1.locked, 1);
        idle(300);
        tick(1649, 749);
        strobe(300);
        check("miss_drop.locked", b1.locked, 0);
        check("miss_drop.hdmiEnable", b1.hdmiEnable, 0);
        check("miss_drop.resyncPulse", b1.resyncPulse, 1);
        idle(300);
        check("miss_drop_after.resyncPulse", b1.resyncPulse, 0);
        check("miss_drop_after.locked", b1.locked, 0);

        // Watchdog with TIMEOUT_FRAMES=3
        strobe(40);
        check("wd_lock.locked", b1.locked, 1);
        check("wd_lock.resyncPulse", b1.resyncPulse, 0);
        idle(40);
        for (int f = 1; f <= 3; f++) begin
            tick(1649, 749);
            check($sformatf("wd_wrap%0d.locked", f), b1.locked, (f < 3) ? 1 : 0);
            check($sformatf("wd_wrap%0d.resyncPulse", f), b1.resyncPulse, (f < 3) ? 0 : 1);
            tick(0, 0);
        end
        check("wd_after.resyncPulse", b1.resyncPulse, 0);

        // Strobe edge on the third wrap keeps lock and restarts the frame count
        strobe(40);
        idle(40);
        tick(1649, 749);
        tick(1649, 749);
        b1.newFrameIn = 1'b1;
        tick(1649, 749);
        check("wd_edge_wins.locked", b1.locked, 1);
        check("wd_edge_wins.resyncPulse", b1.resyncPulse, 0);
        idle(0);
        tick(1649, 749);
        tick(1649, 749);
        check("wd_restart2.locked", b1.locked, 1);
        tick(1649, 749);
        check("wd_restart3.locked", b1.locked, 0);
        check("wd_restart3.resyncPulse", b1.resyncPulse, 1);
        tick(0, 0);

        // Asynchronous reset mid-operation
        strobe(40);
        idle(40);
        tick(500, 100);
        tick(500, 100);
        check("pre_reset.drawWin", b1.drawWin, 1);
        check("pre_reset.hdmiEnable", b1.hdmiEnable, 1);
        #3;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge pxlClk);
        #1;
        check("in_reset.locked", b1.locked, 0);
        rst = 1'b1;
        tick(500, 100);
        check("release.locked", b1.locked, 0);
        check("release.hdmiEnable", b1.hdmiEnable, 0);
        check("release.resyncPulse", b1.resyncPulse, 0);
        check("release.cacheUpdate", b1.cacheUpdate, 0);
        check("release.nextLine", b1.nextLine, 0);
        check("release.drawWin", b1.drawWin, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
